mem_access_ctrl: RTL

//   Initiator side of the data memory_unit port (Address/Wdata/WEn/Rdata).

---
 rtl/mem_access_ctrl_pkg.sv | 45 ++++
 rtl/mem_access_ctrl_if.sv | 42 ++++
 rtl/mem_access_ctrl_byte_lane_merge.sv | 39 +++
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size codes, FSM states, request payload.
// Optional feature macro used by this block: MEM_ALIGN_TRAP_EN.
package mem_access_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Request fields captured at accept; only the low half of store data is needed for merges.
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              sgn;
        logic [1:0]        off;
        logic [HALF_W-1:0] wdata;
    } req_t;

    // Size code 11 behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] code);
        return (code == 2'b11) ? SZ_WORD : size_e'(code);
    endfunction

    // Byte offset inside the word, masked to the natural alignment of the access.
    function automatic logic [1:0] lane_off(input size_e size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port signal bundle for mem_access_ctrl.
// The misalign signal exists only when MEM_ALIGN_TRAP_EN is defined.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;
    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_Wdata;
    logic              mem_WEn;
    logic [DATA_W-1:0] mem_Rdata;
`ifdef MEM_ALIGN_TRAP_EN
    logic              misalign;
`endif

    // Pipeline stage and memory side.
    modport master (
`ifdef MEM_ALIGN_TRAP_EN
        input  misalign,
`endif
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_Rdata,
        input  req_ready, rsp_valid, rsp_rdata, stall, mem_Address, mem_Wdata, mem_WEn
    );

    // Controller side.
    modport slave (
`ifdef MEM_ALIGN_TRAP_EN
        output misalign,
`endif
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_Rdata,
        output req_ready, rsp_valid, rsp_rdata, stall, mem_Address, mem_Wdata, mem_WEn
    );

endinterface

// File: rtl/mem_access_ctrl_byte_lane_merge.sv
// Byte-lane datapath: inserts sub-word store data into a word and extracts/extends
// sub-word load data from a word (little-endian lanes).
module mem_access_ctrl_byte_lane_merge
    import mem_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [HALF_W-1:0] data,
    input  size_e             size,
    input  logic [1:0]        off,
    input  logic              sgn,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extracted
);

    logic [7:0]        byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        byte_v    = word[{off, 3'b000} +: 8];
        half_v    = word[{off[1], 4'b0000} +: HALF_W];
        merged    = word;
        extracted = word;
        case (size)
            SZ_BYTE: begin
                merged[{off, 3'b000} +: 8] = data[7:0];
                extracted = sgn ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            end
            SZ_HALF: begin
                merged[{off[1], 4'b0000} +: HALF_W] = data;
                extracted = sgn ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            end
            default: begin
                merged    = word;
                extracted = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores onto a word-wide memory,
// with read-modify-write for sub-word stores. Define MEM_ALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            CLK,
    input  logic            RST,
    mem_access_ctrl_if.slave bus
);

    state_e              state;
    state_e              state_next;
    req_t                req_q;
    logic                accept;
    logic                trap;
    size_e               size_in;
    logic [1:0]          off_in;
    logic [1:0]          rd_cnt;
    logic                wen_q;
    logic [ADDR_W-3:0]   addr_hi_q;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   extracted;

    assign size_in = norm_size(bus.req_size);
    assign off_in  = lane_off(size_in, bus.req_addr[1:0]);

    // Misaligned half/word detection; without the trap the low bits are simply masked.
    always_comb begin
        trap = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
        if (size_in == SZ_HALF && bus.req_addr[0])
            trap = 1'b1;
        else if (size_in == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            trap = 1'b1;
`endif
    end

    mem_access_ctrl_byte_lane_merge u_lane (
        .word      (bus.mem_Rdata),
        .data      (req_q.wdata),
        .size      (req_q.size),
        .off       (req_q.off),
        .sgn       (req_q.sgn),
        .merged    (merged),
        .extracted (extracted)
    );

    // Next-state logic.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (trap)
                        state_next = RESP;
                    else if (bus.req_we && size_in == SZ_WORD)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                if (rd_cnt == 2'd0)
                    state_next = req_q.we ? WR : RESP;
            end
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            req_q         <= '0;
            rd_cnt        <= 2'd0;
            wen_q         <= 1'b0;
            addr_hi_q     <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_Wdata <= '0;
`ifdef MEM_ALIGN_TRAP_EN
            bus.misalign  <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            bus.req_ready <= (state_next == IDLE);
            bus.rsp_valid <= (state_next == RESP);
            wen_q         <= (state_next == WR);

            if (accept) begin
                req_q.we    <= bus.req_we;
                req_q.size  <= size_in;
                req_q.sgn   <= bus.req_signed;
                req_q.off   <= off_in;
                req_q.wdata <= bus.req_wdata[HALF_W-1:0];
                addr_hi_q   <= bus.req_addr[ADDR_W-1:2];
                if (bus.req_we && size_in == SZ_WORD)
                    bus.mem_Wdata <= bus.req_wdata;
            end

            // RD occupancy: loaded on entry, read word sampled when it reaches zero.
            if (accept && state_next == RD)
                rd_cnt <= 2'(RD_LATENCY);
            else if (state == RD && rd_cnt != 2'd0)
                rd_cnt <= rd_cnt - 2'd1;

            if (state == RD && state_next == WR)
                bus.mem_Wdata <= merged;

            if (state_next == RESP)
                bus.rsp_rdata <= (state == RD) ? extracted : '0;

`ifdef MEM_ALIGN_TRAP_EN
            bus.misalign <= (state == IDLE) && (state_next == RESP);
`endif
        end
    end

    assign bus.mem_Address = {addr_hi_q, 2'b00};
    assign bus.mem_WEn     = wen_q & ~RST;
    assign bus.stall       = bus.req_valid & ~bus.req_ready;

endmodule
